amp_preprocessor: RTL and testbench
===================================

# amp_preprocessor

Per-frame amplitude conditioner between the note-folding stage and the LED/colour mapping stage. On each `start` it captures BIN_QTY unsigned fixed-point note amplitudes and subtracts a noise floor with clamping at zero. It low-pass filters each bin across frames, sums the floored amplitudes, and reports completion with a one-cycle `data_v` pulse.

## Interface
- W, 6: integer bits of every amplitude (unsigned Q W.D).
- D, 10: fractional bits.
- BIN_QTY, 12: number of note bins.
- LEDFloor, 102 (≈0.0996 in Q6.10): noise floor, W+D bits, subtracted from every bin.
- IIR_SHIFT, 2: slow-filter coefficient exponent (alpha = 2^-IIR_SHIFT).
- clk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: reset is synchronous and active-high.
- start, input, 1: level request; sampled only in IDLE.
- noteAmplitudes_i, input, [BIN_QTY][W+D]: raw bin amplitudes; captured on the accepting edge.
- noteAmplitudes_o, output, [BIN_QTY][W+D]: slow (IIR-filtered) floored amplitudes.
- noteAmplitudesFast_o, output, [BIN_QTY][W+D]: instantaneous floored amplitudes of the last frame.
- amplitudeSumNew_o, output, W+D+clog2(BIN_QTY)+1 bits: sum of noteAmplitudesFast_o over all bins.
- data_v, output, 1: one-cycle pulse; outputs updated and valid.

## Operation
- The FSM has three states: IDLE, PROC and DONE.
  - IDLE: on an edge with start=1, capture noteAmplitudes_i into an input register, clear the sum accumulator, set bin index k=0, and go to PROC.
  - PROC: process one bin per cycle, k = 0..BIN_QTY-1. After k = BIN_QTY-1, go to DONE.
  - DONE: copy the working fast, slow and sum registers to the outputs, assert data_v for this cycle only, and return to IDLE.
- Per bin k:
  - fast[k] = in[k] > LEDFloor ? in[k] − LEDFloor : 0. This is an unsigned clamp; the result is never negative.
  - diff = signed(fast[k]) − signed(slow[k]), computed in W+D+1 bits.
  - slow[k] <= slow[k] + (diff >>> IIR_SHIFT), using an arithmetic shift (floor toward −inf).
  - slow[k] stays within [0, 2^(W+D)−1] by construction; no saturation logic is required.
  - acc <= acc + fast[k]. The accumulator is zero-extended to the sum width and cannot overflow.
- Filter state:
  - slow[] persists across frames and is cleared only by rst.
  - fast[] and the sum are recomputed from scratch every frame.
- Outputs change only in the DONE cycle and otherwise hold their last values.
- A change in noteAmplitudes_i after the accepting edge has no effect on the frame in progress.
- start is ignored in PROC and DONE; requests are not queued.
- If start is held high continuously, a new frame is accepted on the first IDLE edge after each DONE.

## Timing
- Reset values:
  - All outputs are 0 and data_v is 0.
  - slow[], fast[], the input register and the accumulator are 0.
  - The state is IDLE and k = 0.
- rst asserted in any state aborts the frame in progress on that edge. No data_v is issued for the aborted frame and the outputs return to 0.
- Latency: with start sampled at edge T, data_v is high during the cycle following edge T+BIN_QTY+1. With BIN_QTY=12, this is the 14th edge after acceptance counting T as the 1st.
- Throughput: one frame per BIN_QTY+2 cycles when start is held high.
- There is no back-pressure. data_v must not be held for longer than one cycle.

## Test plan
- Reset: hold rst for 5 cycles with start=0 -> all outputs are 0, data_v stays 0, and no frame starts.
- Single frame with the default parameters and inputs, in Q6.10, of [7, 8, 5, 0, 2, 2, 2, 7, 4, 6, 4, 1]:
  - noteAmplitudesFast_o = [7066, 8090, 5018, 0, 1946, 1946, 1946, 7066, 3994, 6042, 3994, 922].
  - amplitudeSumNew_o = 48030.
  - noteAmplitudes_o[0] = 1766 and noteAmplitudes_o[3] = 0.
  - data_v pulses for exactly one cycle, at the required latency.
- Repeat the same input with start held high -> three data_v pulses spaced BIN_QTY+2 cycles apart. noteAmplitudes_o[0] goes 1766, then 3091, then 4084; fast and sum are identical every frame.
- Floor clamp: a bin at 0, at 102 and at 103 -> fast values 0, 0 and 1.
- Decay: after converging on 7.0, feed all-zero inputs -> noteAmplitudes_o decreases monotonically toward 0 and never wraps negative; the sum is 0.
- Robustness:
  - Assert rst mid-PROC -> no data_v and outputs are cleared.
  - Toggle noteAmplitudes_i during PROC -> results match the values captured at acceptance.

Source files
------------

// File: rtl/amp_preprocessor.sv
// Per-frame amplitude conditioner: floors each note bin, low-pass filters it across
// frames and sums the floored bins, one bin per cycle, then publishes with data_v.
module amp_preprocessor #(
    parameter int              W         = 6,
    parameter int              D         = 10,
    parameter int              BIN_QTY   = 12,
    parameter logic [W+D-1:0]  LEDFloor  = (W+D)'(102),
    parameter int              IIR_SHIFT = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [BIN_QTY-1:0][W+D-1:0]           noteAmplitudes_i,
    output logic [BIN_QTY-1:0][W+D-1:0]           noteAmplitudes_o,
    output logic [BIN_QTY-1:0][W+D-1:0]           noteAmplitudesFast_o,
    output logic [W+D+$clog2(BIN_QTY):0]          amplitudeSumNew_o,
    output logic                                  data_v
);

    localparam int DW = W + D;
    localparam int SW = DW + $clog2(BIN_QTY) + 1;
    localparam int KW = $clog2(BIN_QTY);

    typedef enum logic [1:0] {
        IDLE,
        PROC,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [KW-1:0]     k_q;
    logic              last_bin;

    logic [DW-1:0]     in_reg   [BIN_QTY];
    logic [DW-1:0]     fast_reg [BIN_QTY];
    logic [DW-1:0]     slow_reg [BIN_QTY];
    logic [SW-1:0]     acc;

    logic [DW-1:0]     cur_in;
    logic [DW-1:0]     slow_cur;
    logic [DW-1:0]     fast_val;
    logic signed [DW:0] diff;
    logic signed [DW:0] step;
    logic [DW-1:0]     slow_next;

    assign last_bin = (k_q == KW'(BIN_QTY - 1));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PROC;
            PROC:    if (last_bin) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Per-bin arithmetic for the bin currently addressed by k.
    always_comb begin
        cur_in    = in_reg[k_q];
        slow_cur  = slow_reg[k_q];
        fast_val  = (cur_in > LEDFloor) ? (cur_in - LEDFloor) : '0;
        diff      = $signed({1'b0, fast_val}) - $signed({1'b0, slow_cur});
        step      = diff >>> IIR_SHIFT;
        // The filter result always lands in [0, 2^DW-1], so dropping the sign bit is exact.
        slow_next = DW'($signed({1'b0, slow_cur}) + step);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the bin arrays are reset because slow[] is filter state that must start from zero.
            for (int i = 0; i < BIN_QTY; i++) begin
                in_reg[i]               <= '0;
                fast_reg[i]             <= '0;
                slow_reg[i]             <= '0;
                noteAmplitudes_o[i]     <= '0;
                noteAmplitudesFast_o[i] <= '0;
            end
            acc               <= '0;
            k_q               <= '0;
            amplitudeSumNew_o <= '0;
            data_v            <= 1'b0;
        end else begin
            data_v <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < BIN_QTY; i++) in_reg[i] <= noteAmplitudes_i[i];
                        acc <= '0;
                        k_q <= '0;
                    end
                end
                PROC: begin
                    fast_reg[k_q] <= fast_val;
                    slow_reg[k_q] <= slow_next;
                    acc           <= acc + SW'(fast_val);
                    k_q           <= last_bin ? '0 : k_q + KW'(1);
                end
                DONE: begin
                    for (int i = 0; i < BIN_QTY; i++) begin
                        noteAmplitudes_o[i]     <= slow_reg[i];
                        noteAmplitudesFast_o[i] <= fast_reg[i];
                    end
                    amplitudeSumNew_o <= acc;
                    data_v            <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_amp_preprocessor.sv
// Self-checking bench for amp_preprocessor: table vectors, start-held and reset sequences,
// decay run and randomized frames checked against an arithmetic reference model.
module tb_amp_preprocessor;

    localparam int BQ     = 12;
    localparam int DW     = 16;
    localparam int SW     = 21;
    localparam int SHIFT  = 2;
    localparam int FLOOR  = 102;
    localparam int LAT    = 14;
    localparam int PERIOD = BQ + 2;

    typedef logic [BQ-1:0][DW-1:0] frame_t;
    typedef struct packed {
        frame_t          amp;
        frame_t          fast;
        logic [SW-1:0]   sum;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          start;
    frame_t        noteAmplitudes_i;
    frame_t        noteAmplitudes_o;
    frame_t        noteAmplitudesFast_o;
    logic [SW-1:0] amplitudeSumNew_o;
    logic          data_v;

    int     errors = 0;
    int     checks = 0;
    int     slow_m [BQ];
    frame_t exp_fast;
    int     exp_sum;
    vec_t   vecs [3];

    amp_preprocessor dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .noteAmplitudes_i     (noteAmplitudes_i),
        .noteAmplitudes_o     (noteAmplitudes_o),
        .noteAmplitudesFast_o (noteAmplitudesFast_o),
        .amplitudeSumNew_o    (amplitudeSumNew_o),
        .data_v               (data_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Floor division of diff by 2^SHIFT (rounds toward minus infinity).
    function automatic int floor_step(input int diff);
        int div;
        div = 1 << SHIFT;
        if (diff >= 0) return diff / div;
        return -((-diff + div - 1) / div);
    endfunction

    task automatic model_frame(input frame_t fr);
        int a;
        int f;
        exp_sum = 0;
        for (int k = 0; k < BQ; k++) begin
            a = int'(fr[k]);
            f = (a > FLOOR) ? a - FLOOR : 0;
            exp_fast[k] = DW'(f);
            exp_sum += f;
            slow_m[k] = slow_m[k] + floor_step(f - slow_m[k]);
        end
    endtask

    task automatic compare_outputs(input string tag);
        for (int k = 0; k < BQ; k++) begin
            check($sformatf("%s fast[%0d]", tag, k), noteAmplitudesFast_o[k], exp_fast[k]);
            check($sformatf("%s slow[%0d]", tag, k), noteAmplitudes_o[k], slow_m[k]);
        end
        check($sformatf("%s sum", tag), amplitudeSumNew_o, exp_sum);
    endtask

    function automatic frame_t random_frame();
        frame_t fr;
        for (int k = 0; k < BQ; k++) begin
            if ($urandom_range(0, 3) == 0) fr[k] = DW'($urandom_range(0, 210));
            else                           fr[k] = DW'($urandom_range(0, 65535));
        end
        return fr;
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < BQ; k++) slow_m[k] = 0;
    endtask

    // One frame: request at a negedge, drop start after the accepting edge, wait for data_v.
    task automatic run_frame(input frame_t fr, input bit toggle, input string tag);
        int            n;
        logic [SW-1:0] prev_sum;
        prev_sum = amplitudeSumNew_o;
        @(negedge clk);
        noteAmplitudes_i = fr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        model_frame(fr);
        while (data_v !== 1'b1 && n < 40) begin
            if (n == LAT - 1) check($sformatf("%s hold sum", tag), amplitudeSumNew_o, prev_sum);
            if (toggle) noteAmplitudes_i = random_frame();
            @(negedge clk);
            n++;
        end
        check($sformatf("%s latency", tag), n, LAT);
        compare_outputs(tag);
        @(negedge clk);
        check($sformatf("%s pulse width", tag), data_v, 0);
    endtask

    initial begin : main
        int     a_tab [3][BQ];
        int     f_tab [3][BQ];
        int     s_tab [3];
        int     exp_s0 [3];
        frame_t fr;
        frame_t prev;
        int     n;
        int     pulses;
        int     last;

        a_tab[0] = '{7, 8, 5, 0, 2, 2, 2, 7, 4, 6, 4, 1};
        f_tab[0] = '{7066, 8090, 5018, 0, 1946, 1946, 1946, 7066, 3994, 6042, 3994, 922};
        s_tab[0] = 48030;
        a_tab[1] = '{0, 102, 103, 101, 104, 65535, 1024, 0, 102, 103, 200, 1};
        f_tab[1] = '{0, 0, 1, 0, 2, 65433, 922, 0, 0, 1, 98, 0};
        s_tab[1] = 66457;
        a_tab[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        f_tab[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        s_tab[2] = 0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < BQ; k++) begin
                // Only the first vector is in whole units; the others are raw Q6.10 codes.
                vecs[i].amp[k]  = DW'((i == 0) ? a_tab[i][k] * 1024 : a_tab[i][k]);
                vecs[i].fast[k] = DW'(f_tab[i][k]);
            end
            vecs[i].sum = SW'(s_tab[i]);
        end
        exp_s0 = '{1766, 3091, 4084};

        rst = 1'b1;
        start = 1'b0;
        noteAmplitudes_i = random_frame();

        // Reset: 5 cycles with start low, then idle with no frame starting.
        repeat (5) begin
            @(negedge clk);
            check("reset data_v", data_v, 0);
        end
        for (int k = 0; k < BQ; k++) begin
            check($sformatf("reset fast[%0d]", k), noteAmplitudesFast_o[k], 0);
            check($sformatf("reset slow[%0d]", k), noteAmplitudes_o[k], 0);
        end
        check("reset sum", amplitudeSumNew_o, 0);
        rst = 1'b0;
        for (int k = 0; k < BQ; k++) slow_m[k] = 0;
        repeat (20) begin
            @(negedge clk);
            check("idle data_v", data_v, 0);
        end

        // Table vectors, applied from a clean filter state.
        for (int i = 0; i < 3; i++) begin
            run_frame(vecs[i].amp, 1'b0, $sformatf("vec%0d", i));
            for (int k = 0; k < BQ; k++)
                check($sformatf("vec%0d table fast[%0d]", i, k), noteAmplitudesFast_o[k], vecs[i].fast[k]);
            check($sformatf("vec%0d table sum", i), amplitudeSumNew_o, vecs[i].sum);
            if (i == 0) begin
                check("vec0 slow[0]", noteAmplitudes_o[0], 1766);
                check("vec0 slow[3]", noteAmplitudes_o[3], 0);
            end
        end

        // start held high: three back-to-back frames.
        do_reset(2);
        @(negedge clk);
        noteAmplitudes_i = vecs[0].amp;
        start = 1'b1;
        n = 0;
        pulses = 0;
        last = 0;
        while (pulses < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (data_v === 1'b1) begin
                model_frame(vecs[0].amp);
                compare_outputs($sformatf("held%0d", pulses));
                check($sformatf("held%0d slow[0]", pulses), noteAmplitudes_o[0], exp_s0[pulses]);
                check($sformatf("held%0d table sum", pulses), amplitudeSumNew_o, vecs[0].sum);
                if (pulses == 0) check("held first latency", n, LAT);
                else             check($sformatf("held%0d spacing", pulses), n - last, PERIOD);
                last = n;
                pulses++;
                if (pulses == 3) start = 1'b0;
            end
        end
        check("held pulse count", pulses, 3);
        repeat (20) begin
            @(negedge clk);
            check("held no extra frame", data_v, 0);
        end

        // Reset mid-PROC aborts the frame and clears the outputs.
        run_frame(random_frame(), 1'b0, "pre-abort");
        @(negedge clk);
        noteAmplitudes_i = random_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < BQ; k++) slow_m[k] = 0;
        repeat (25) begin
            @(negedge clk);
            check("abort data_v", data_v, 0);
        end
        for (int k = 0; k < BQ; k++) begin
            check($sformatf("abort fast[%0d]", k), noteAmplitudesFast_o[k], 0);
            check($sformatf("abort slow[%0d]", k), noteAmplitudes_o[k], 0);
        end
        check("abort sum", amplitudeSumNew_o, 0);
        run_frame(vecs[0].amp, 1'b0, "post-abort");
        check("post-abort slow[0]", noteAmplitudes_o[0], 1766);

        // Decay: converge on 7.0 then feed zeros.
        do_reset(2);
        for (int k = 0; k < BQ; k++) fr[k] = DW'(7 * 1024);
        repeat (20) run_frame(fr, 1'b0, "converge");
        fr = '0;
        for (int f = 0; f < 40; f++) begin
            prev = noteAmplitudes_o;
            run_frame(fr, 1'b0, "decay");
            for (int k = 0; k < BQ; k++) begin
                if (prev[k] == 0)
                    check($sformatf("decay%0d zero[%0d]", f, k), noteAmplitudes_o[k], 0);
                else
                    check($sformatf("decay%0d falls[%0d]", f, k),
                          longint'(noteAmplitudes_o[k] < prev[k]), 1);
            end
        end
        for (int k = 0; k < BQ; k++)
            check($sformatf("decay final[%0d]", k), noteAmplitudes_o[k], 0);

        // Randomized frames with inputs toggled while the frame is processed.
        for (int f = 0; f < 25; f++)
            run_frame(random_frame(), 1'b1, $sformatf("rand%0d", f));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
